// File: rtl/alu1_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU1 between several requesters.
// Tracks the owner of every in-flight op and supports a flush/drain handshake.

package alu1_pkg;
    localparam int unsigned ALU1_CMD_WIDTH   = 4;
    localparam int unsigned ALU1_NR_COMMANDS = 8;

    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_ADD  = 4'd0;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SUB  = 4'd1;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_AND  = 4'd2;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_OR   = 4'd3;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_XOR  = 4'd4;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SLL  = 4'd5;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SRL  = 4'd6;
    localparam logic [ALU1_CMD_WIDTH-1:0] ALU1_SLTU = 4'd7;
endpackage

module alu1_arbiter #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned NR_REQ      = 4,
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned CMD_WIDTH   = alu1_pkg::ALU1_CMD_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NR_REQ-1:0]           req_valid,
    output logic [NR_REQ-1:0]           req_ready,
    input  logic [NR_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NR_REQ*WIDTH-1:0]     req_in1,
    input  logic [NR_REQ*WIDTH-1:0]     req_in2,
    output logic [NR_REQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]            rsp_result,
    output logic                        alu_valid,
    output logic [CMD_WIDTH-1:0]        alu_cmd,
    output logic [WIDTH-1:0]            alu_in1,
    output logic [WIDTH-1:0]            alu_in2,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(NR_REQ);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 3);

    typedef enum logic [1:0] {StRun, StDrain, StFlushed} state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic [SUM_W-1:0]     sum;
    logic                 found;
    logic                 grant_en;
    logic                 accept;
    logic [CMD_WIDTH-1:0] sel_cmd;
    logic [WIDTH-1:0]     sel_in1;
    logic [WIDTH-1:0]     sel_in2;
    logic [IDX_W-1:0]     tag_q [ALU_LATENCY+1];
    logic [ALU_LATENCY:0] tvld_q;
    logic [NR_REQ-1:0]    rsp_dec;
    logic                 rsp_any;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_d;

    // Grants are blocked during reset and from the very cycle flush_req rises.
    assign grant_en = rst_n && (state_q == StRun) && !flush_req;
    assign accept   = found && grant_en;
    assign rsp_any  = |rsp_valid;
    assign busy     = (inflight_q != '0);

    // Rotating-priority search starting at the round-robin pointer.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            sum = {1'b0, ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NR_REQ)) begin
                sum = sum - SUM_W'(NR_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_cmd = '0;
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                sel_in1 = req_in1[i*WIDTH +: WIDTH];
                sel_in2 = req_in2[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (grant_idx == IDX_W'(NR_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Operand registers hold their value when nothing is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
        end else begin
            alu_valid <= accept;
            if (accept) begin
                alu_cmd <= sel_cmd;
                alu_in1 <= sel_in1;
                alu_in2 <= sel_in2;
            end
        end
    end

    // Stage 0 loads alongside the ALU operands; the last stage lines up with alu_result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvld_q <= '0;
            for (int s = 0; s <= ALU_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tvld_q[0] <= accept;
            tag_q[0]  <= grant_idx;
            for (int s = 1; s <= ALU_LATENCY; s++) begin
                tvld_q[s] <= tvld_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        rsp_dec = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            rsp_dec[i] = tvld_q[ALU_LATENCY] && (tag_q[ALU_LATENCY] == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= rsp_dec;
            if (tvld_q[ALU_LATENCY]) begin
                rsp_result <= alu_result;
            end
        end
    end

    // Count covers the tag pipe plus the response register.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !rsp_any) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && rsp_any) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            flush_done <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (flush_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (inflight_q == '0) begin
                        state_q    <= StFlushed;
                        flush_done <= 1'b1;
                    end
                end
                StFlushed: begin
                    if (!flush_req) begin
                        state_q    <= StRun;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu1_arbiter.sv
// Directed bench for alu1_arbiter with a one-cycle-latency ALU model attached.

module tb_alu1_arbiter;
    import alu1_pkg::*;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int CW = ALU1_CMD_WIDTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_cmd = '0;
    logic [N*W-1:0]  req_in1 = '0;
    logic [N*W-1:0]  req_in2 = '0;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_result;
    logic            alu_valid;
    logic [CW-1:0]   alu_cmd;
    logic [W-1:0]    alu_in1;
    logic [W-1:0]    alu_in2;
    logic [W-1:0]    alu_result = '0;
    logic            flush_req = 1'b0;
    logic            flush_done;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ones;
    logic [W-1:0] exp_a [8];
    logic [W-1:0] exp_b [8];

    alu1_arbiter #(
        .WIDTH      (W),
        .NR_REQ     (N),
        .ALU_LATENCY(1),
        .CMD_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .alu_valid (alu_valid),
        .alu_cmd   (alu_cmd),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_result(alu_result),
        .flush_req (flush_req),
        .flush_done(flush_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [CW-1:0] c, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (c)
            ALU1_ADD:  return a + b;
            ALU1_SUB:  return a - b;
            ALU1_AND:  return a & b;
            ALU1_OR:   return a | b;
            ALU1_XOR:  return a ^ b;
            ALU1_SLL:  return a << b[5:0];
            ALU1_SRL:  return a >> b[5:0];
            ALU1_SLTU: return {{(W-1){1'b0}}, (a < b)};
            default:   return '0;
        endcase
    endfunction

    // ALU with one cycle of latency.
    always @(posedge clk) alu_result <= alu_model(alu_cmd, alu_in1, alu_in2);

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [CW-1:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req_cmd[i*CW +: CW] = c;
        req_in1[i*W +: W]   = a;
        req_in2[i*W +: W]   = b;
    endtask

    initial begin
        ones = '1;
        // (in1=0, in2=all-ones) and (in1=all-ones, in2=0), opcodes 0..7
        exp_a[0] = ones; exp_a[1] = 64'd1; exp_a[2] = 64'd0; exp_a[3] = ones;
        exp_a[4] = ones; exp_a[5] = 64'd0; exp_a[6] = 64'd0; exp_a[7] = 64'd1;
        exp_b[0] = ones; exp_b[1] = ones;  exp_b[2] = 64'd0; exp_b[3] = ones;
        exp_b[4] = ones; exp_b[5] = ones;  exp_b[6] = ones;  exp_b[7] = 64'd0;

        // Reset and single op
        set_op(0, ALU1_ADD, 64'd5, 64'd7);
        req_valid = 4'b0001;
        #1;
        chk("ready_in_reset", W'(req_ready), 64'd0);
        tick();
        tick();
        chk("rst_alu_valid", W'(alu_valid), 64'd0);
        chk("rst_alu_in1", alu_in1, 64'd0);
        chk("rst_rsp_valid", W'(rsp_valid), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_busy", W'(busy), 64'd0);
        chk("rst_flush_done", W'(flush_done), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", W'(req_ready), 64'd1);
        tick();
        req_valid = 4'b0000;
        chk("t1_alu_valid", W'(alu_valid), 64'd1);
        chk("t1_alu_cmd", W'(alu_cmd), W'(ALU1_ADD));
        chk("t1_alu_in1", alu_in1, 64'd5);
        chk("t1_alu_in2", alu_in2, 64'd7);
        chk("t1_busy", W'(busy), 64'd1);
        tick();
        chk("t1_alu_valid_off", W'(alu_valid), 64'd0);
        chk("t1_rsp_early", W'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid", W'(rsp_valid), 64'd1);
        chk("t1_rsp_result", rsp_result, 64'd12);
        tick();
        chk("t1_rsp_off", W'(rsp_valid), 64'd0);
        chk("t1_rsp_hold", rsp_result, 64'd12);
        chk("t1_busy_off", W'(busy), 64'd0);

        // All four requesting from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, ALU1_ADD, W'(100 + i), W'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_ready", W'(req_ready), 64'd1 << (k % 4));
            tick();
            chk("t2_alu_in1", alu_in1, W'(100 + (k % 4)));
            if (k >= 2) begin
                chk("t2_rsp_valid", W'(rsp_valid), 64'd1 << ((k - 2) % 4));
                chk("t2_rsp_result", rsp_result, W'(100 + 2 * ((k - 2) % 4)));
            end else begin
                chk("t2_rsp_none", W'(rsp_valid), 64'd0);
            end
        end
        req_valid = 4'b0000;
        tick();
        chk("t2_rsp_tail0", W'(rsp_valid), 64'b0100);
        chk("t2_res_tail0", rsp_result, 64'd104);
        tick();
        chk("t2_rsp_tail1", W'(rsp_valid), 64'b1000);
        chk("t2_res_tail1", rsp_result, 64'd106);
        tick();

        // Only requesters 1 and 3
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ready", W'(req_ready), (k % 2 == 0) ? 64'b0010 : 64'b1000);
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();

        // Flush while ops are in flight
        set_op(0, ALU1_ADD, 64'd1, 64'd2);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_ready", W'(req_ready), 64'd1);
            tick();
        end
        chk("t4_rsp_a", W'(rsp_valid), 64'd1);
        flush_req = 1'b1;
        #1;
        chk("t4_ready_flush_rise", W'(req_ready), 64'd0);
        tick();
        chk("t4_rsp_b", W'(rsp_valid), 64'd1);
        chk("t4_no_issue", W'(alu_valid), 64'd0);
        tick();
        chk("t4_rsp_c", W'(rsp_valid), 64'd1);
        chk("t4_res_c", rsp_result, 64'd3);
        chk("t4_busy_c", W'(busy), 64'd1);
        chk("t4_done_early", W'(flush_done), 64'd0);
        tick();
        chk("t4_busy_fall", W'(busy), 64'd0);
        chk("t4_done_not_yet", W'(flush_done), 64'd0);
        tick();
        chk("t4_flush_done", W'(flush_done), 64'd1);
        chk("t4_ready_flushed", W'(req_ready), 64'd0);
        flush_req = 1'b0;
        #1;
        chk("t4_ready_release", W'(req_ready), 64'd0);
        tick();
        chk("t4_done_clear", W'(flush_done), 64'd0);
        #1;
        chk("t4_ready_resume", W'(req_ready), 64'd1);

        // Reset with an op in flight
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_ready_rst", W'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        chk("t5_busy", W'(busy), 64'd0);
        chk("t5_alu_valid", W'(alu_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("t5_no_rsp", W'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        chk("t5_ptr_zero", W'(req_ready), 64'd1);
        req_valid = 4'b0100;
        #1;
        chk("t5_ready2", W'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0000;
        chk("t5_issue2", alu_in1, 64'd102);
        tick();
        tick();
        tick();

        // Every opcode against 0 / all-ones
        for (int pass = 0; pass < 2; pass++) begin
            for (int op = 0; op < int'(ALU1_NR_COMMANDS); op++) begin
                if (pass == 0) set_op(0, CW'(op), 64'd0, ones);
                else set_op(0, CW'(op), ones, 64'd0);
                req_valid = 4'b0001;
                tick();
                req_valid = 4'b0000;
                tick();
                tick();
                chk("t6_rsp_valid", W'(rsp_valid), 64'd1);
                chk(pass == 0 ? "t6_res_0_ones" : "t6_res_ones_0", rsp_result,
                    pass == 0 ? exp_a[op] : exp_b[op]);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
